// File: rtl/req_arb16.sv
// req_arb16: sixteen-client request collector with a single-grant valid/ready/done arbiter.
// Define REQ_ARB16_RR_EN for round-robin selection; fixed priority (bit 0 first) otherwise.
module req_arb16 #(
    parameter int unsigned SERVE_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] pending,
    output logic        gnt_valid,
    output logic [3:0]  gnt_id,
    input  logic        gnt_ready,
    input  logic        done,
    output logic        busy,
    output logic        timeout,
    output logic        overflow,
    input  logic        ovf_clr
);
    typedef enum logic [1:0] {IDLE, OFFER, SERVE} state_t;
    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] elig;
    logic [15:0] clr;
    logic [3:0]  sel;
    logic        accept;
    logic        ovf_hit;
`ifdef REQ_ARB16_RR_EN
    logic [3:0]  last;
    logic [15:0] above;
    // Clients after the last accepted one get first pick; wrap to all of pending when none remain.
    assign above = pending & (16'hFFFF << ({1'b0, last} + 5'd1));
    assign elig  = (above != 16'd0) ? above : pending;
`else
    assign elig  = pending;
`endif
    always_comb begin
        sel = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (elig[i]) sel = 4'(i);
    end
    assign accept  = (state == OFFER) && gnt_ready;
    assign clr     = accept ? (16'd1 << gnt_id) : 16'd0;
    assign ovf_hit = |(req & pending & ~clr);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 16'd0;
            gnt_valid <= 1'b0;
            gnt_id    <= 4'd0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= 8'd0;
`ifdef REQ_ARB16_RR_EN
            last      <= 4'd15;
`endif
        end else begin
            pending  <= (pending & ~clr) | req;
            overflow <= ovf_hit | (overflow & ~ovf_clr);
            timeout  <= 1'b0;
            case (state)
                IDLE: if (|pending) begin
                    gnt_id    <= sel;
                    gnt_valid <= 1'b1;
                    state     <= OFFER;
                end
                OFFER: if (gnt_ready) begin
                    gnt_valid <= 1'b0;
                    busy      <= 1'b1;
                    cnt       <= 8'd0;
                    state     <= SERVE;
`ifdef REQ_ARB16_RR_EN
                    last      <= gnt_id;
`endif
                end
                SERVE: if (done) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if ({1'b0, cnt} + 9'd1 >= 9'(SERVE_MAX)) begin
                    busy    <= 1'b0;
                    timeout <= 1'b1;
                    state   <= IDLE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_req_arb16.sv
// tb_req_arb16: randomized and directed checks of req_arb16 against a transaction-level reference model.
module tb_req_arb16;
    localparam int SMAX = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'd0;
    logic        gnt_ready = 1'b0;
    logic        done = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [15:0] pending;
    logic        gnt_valid;
    logic [3:0]  gnt_id;
    logic        busy;
    logic        timeout;
    logic        overflow;
    int n_tests = 0;
    int n_fail = 0;

    req_arb16 #(.SERVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .req(req), .pending(pending),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_ready(gnt_ready),
        .done(done), .busy(busy), .timeout(timeout),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 waiting, 1 offering, 2 servicing.
    bit [15:0] m_pend = 16'd0;
    int        m_ph = 0;
    int        m_id = 0;
    int        m_cnt = 0;
    int        m_last = 15;
    bit        m_to = 1'b0;
    bit        m_ovf = 1'b0;

    function automatic int pick(input bit [15:0] p, input int last);
`ifdef REQ_ARB16_RR_EN
        for (int k = 1; k <= 16; k++)
            if (p[(last + k) % 16]) return (last + k) % 16;
`else
        for (int j = 0; j < 16; j++)
            if (p[j]) return j;
`endif
        return 0;
    endfunction

    always @(posedge clk) begin : model_b
        bit        acc;
        bit        hit;
        if (rst) begin
            m_pend = 16'd0; m_ph = 0; m_id = 0; m_cnt = 0; m_last = 15; m_to = 1'b0; m_ovf = 1'b0;
        end else begin
            acc = (m_ph == 1) && gnt_ready;
            hit = 1'b0;
            for (int i = 0; i < 16; i++)
                if (req[i] && m_pend[i] && !(acc && i == m_id)) hit = 1'b1;
            if (acc) m_pend[m_id] = 1'b0;
            m_to = 1'b0;
            if (m_ph == 0 && m_pend != 16'd0) begin
                m_id = pick(m_pend, m_last);
                m_ph = 1;
            end else if (acc) begin
                m_last = m_id;
                m_cnt = 0;
                m_ph = 2;
            end else if (m_ph == 2) begin
                if (done) m_ph = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == SMAX) begin
                        m_to = 1'b1;
                        m_ph = 0;
                    end
                end
            end
            m_pend = m_pend | req;
            m_ovf = hit | (m_ovf & ~ovf_clr);
        end
    end

    wire [23:0] obs = {pending, gnt_valid, gnt_id, busy, timeout, overflow};

    function automatic logic [23:0] exp_vec();
        return {m_pend, m_ph == 1, 4'(m_id), m_ph == 2, m_to, m_ovf};
    endfunction

    task automatic step(input logic [15:0] r, input logic rd, input logic dn, input logic oc);
        req = r; gnt_ready = rd; done = dn; ovf_clr = oc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 120; k++) begin
            if (pending == 16'd0 && !gnt_valid && !busy) break;
            step(16'd0, 1'b1, busy, 1'b0);
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL drain_model obs=%h exp=%h", obs, exp_vec()); end
        end
        n_tests++;
        if (pending !== 16'd0 || gnt_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drain_idle pending=%h valid=%b busy=%b want 0/0/0", pending, gnt_valid, busy);
        end
    endtask

    task automatic collect(input int inj_id, input int n, output int g[4], output int cnt);
        bit injected = 1'b0;
        logic [15:0] r;
        cnt = 0;
        for (int k = 0; k < 4; k++) g[k] = -1;
        step(16'h8101, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 60 && cnt < n; k++) begin
            r = 16'd0;
            if (inj_id >= 0 && busy && cnt > 0 && g[cnt-1] == inj_id && !injected) begin
                r = 16'h0001;
                injected = 1'b1;
            end
            step(r, 1'b1, busy, 1'b0);
            if (gnt_valid) begin
                g[cnt] = int'(gnt_id);
                cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(16'd0, 1'b0, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs !== 24'd0) begin n_fail++; $display("FAIL reset_values obs=%h want 000000", obs); end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_model obs=%h exp=%h", obs, exp_vec()); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        step(16'h0001, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (pending !== 16'h0001 || gnt_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_pending pending=%h valid=%b want 0001/0", pending, gnt_valid);
        end
        step(16'd0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (gnt_valid !== 1'b1 || gnt_id !== 4'd0) begin
            n_fail++; $display("FAIL basic_grant valid=%b id=%0d want 1/0", gnt_valid, gnt_id);
        end
        step(16'd0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || pending !== 16'd0 || gnt_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_accept busy=%b pending=%h valid=%b want 1/0000/0", busy, pending, gnt_valid);
        end
        step(16'd0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL basic_done busy=%b timeout=%b want 0/0", busy, timeout);
        end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL basic_model obs=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_order();
        int g[4];
        int c;
        int want[3] = '{0, 8, 15};
        collect(-1, 3, g, c);
        n_tests++;
        if (c != 3) begin n_fail++; $display("FAIL order_count got=%0d want 3", c); end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (g[k] != want[k]) begin n_fail++; $display("FAIL order_%0d got=%0d want %0d", k, g[k], want[k]); end
        end
        drain();
    endtask

    task automatic test_preempt();
        int g[4];
        int c;
`ifdef REQ_ARB16_RR_EN
        int want[4] = '{0, 8, 15, 0};
`else
        int want[4] = '{0, 8, 0, 15};
`endif
        collect(8, 4, g, c);
        n_tests++;
        if (c != 4) begin n_fail++; $display("FAIL preempt_count got=%0d want 4", c); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (g[k] != want[k]) begin n_fail++; $display("FAIL preempt_%0d got=%0d want %0d", k, g[k], want[k]); end
        end
        drain();
    endtask

    task automatic test_overflow();
        step(16'd0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_init got=%b want 0", overflow); end
        step(16'h0008, 1'b0, 1'b0, 1'b0);
        step(16'h0008, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want 1", overflow); end
        step(16'h0008, 1'b0, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b want 1", overflow); end
        step(16'd0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want 0", overflow); end
        step(16'h0008, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b want 1", overflow); end
        step(16'h0008, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (overflow !== 1'b0 || pending[3] !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ovf_accept_rereq ovf=%b p3=%b busy=%b want 0/1/1", overflow, pending[3], busy);
        end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL ovf_model obs=%h exp=%h", obs, exp_vec()); end
        drain();
    endtask

    task automatic test_timeout();
        int pulses;
        int at;
        for (int v = 0; v < 2; v++) begin
            step(16'h0010, 1'b0, 1'b0, 1'b0);
            step(16'd0, 1'b0, 1'b0, 1'b0);
            step(16'd0, 1'b1, 1'b0, 1'b0);
            pulses = 0;
            at = -1;
            for (int k = 1; k <= 6; k++) begin
                step(16'd0, 1'b0, (v == 1 && k == SMAX) ? 1'b1 : 1'b0, 1'b0);
                n_tests++;
                if (obs !== exp_vec()) begin n_fail++; $display("FAIL timeout_model v=%0d k=%0d obs=%h exp=%h", v, k, obs, exp_vec()); end
                if (timeout) begin pulses++; at = k; end
                if (k == SMAX) begin
                    n_tests++;
                    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle v=%0d busy=%b want 0", v, busy); end
                end
            end
            n_tests++;
            if (v == 0 && (pulses != 1 || at != SMAX)) begin
                n_fail++; $display("FAIL timeout_pulse pulses=%0d at=%0d want 1 at %0d", pulses, at, SMAX);
            end
            if (v == 1 && pulses != 0) begin
                n_fail++; $display("FAIL timeout_done_wins pulses=%0d want 0", pulses);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] acc = 16'd0;
        logic [15:0] r;
        step(16'h0002, 1'b0, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            r = 16'($urandom) & 16'hFFFC;
            acc = acc | r;
            step(r, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (gnt_valid !== 1'b1 || gnt_id !== 4'd1 || (pending & acc) !== acc || pending[1] !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold valid=%b id=%0d pending=%h want 1/1/%h", gnt_valid, gnt_id, pending, acc | 16'h0002);
            end
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL stall_model obs=%h exp=%h", obs, exp_vec()); end
        end
        drain();
        step(16'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_rst_mid();
        step(16'h0001, 1'b0, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0, 1'b0);
        step(16'h00F0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || pending !== 16'h00F0) begin
            n_fail++; $display("FAIL rstmid_setup busy=%b pending=%h want 1/00f0", busy, pending);
        end
        rst = 1'b1;
        step(16'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        n_tests++;
        if (obs !== 24'd0) begin n_fail++; $display("FAIL rstmid_values obs=%h want 000000", obs); end
        step(16'd0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (timeout !== 1'b0 || busy !== 1'b0 || gnt_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet timeout=%b busy=%b valid=%b want 0/0/0", timeout, busy, gnt_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        for (int k = 0; k < 500; k++) begin
            r = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'd0;
            rst = ($urandom_range(0, 99) == 0);
            step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_model k=%0d obs=%h exp=%h", k, obs, exp_vec()); end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_preempt();
        test_overflow();
        test_timeout();
        test_stall();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/req_arb16.md
# req_arb16

Sixteen-client request collector and arbiter. Latches single-cycle request strobes into a pending vector and picks one client per transaction with a priority encoder. It offers the winner downstream through a valid/ready handshake, then holds off further grants until the downstream consumer signals completion or a timeout fires. It sits directly in front of the 16-way priority encoder path: it turns raw per-client strobes into a serialized, one-at-a-time grant stream.

## Interface
- SERVE_MAX, 255: maximum cycles in SERVE without `done` before the grant is abandoned; 1..255.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  16  request strobes; bit i high for one cycle sets pending[i].
- pending  out  16  registered pending-request vector.
- gnt_valid  out  1  grant offered.
- gnt_id  out  4  granted client index; stable while gnt_valid=1.
- gnt_ready  in  1  downstream accepts the grant.
- done  in  1  downstream finished servicing the current grant.
- busy  out  1  high in SERVE.
- timeout  out  1  one-cycle pulse when SERVE_MAX expires.
- overflow  out  1  sticky: a request hit an already-pending bit.
- ovf_clr  in  1  clears overflow.

## Operation
- States: IDLE, OFFER, SERVE.
  - IDLE: if pending≠0, register the selected index into gnt_id and go to OFFER. Otherwise stay.
  - OFFER: gnt_valid=1. On gnt_ready=1, clear pending[gnt_id], reset the service counter to 0, and go to SERVE.
  - SERVE: busy=1; the counter increments each cycle.
    - done=1: go to IDLE.
    - Counter reaches SERVE_MAX with done=0: pulse timeout and go to IDLE.
    - done and limit in the same cycle: done wins, no timeout.
- done is ignored outside SERVE. gnt_ready is ignored outside OFFER.
- Pending update per bit i: next = (pending[i] & ~clr_i) | req[i].
  - clr_i is acceptance of i.
  - req[i] in the acceptance cycle of i leaves pending[i]=1 and is not an overflow.
  - req[i] while pending[i]=1 and not being cleared sets overflow.
- overflow: set wins over ovf_clr in the same cycle.
- Selection: lowest set index of the eligible vector (bit 0 highest priority). Selection mode depends on configuration.
- Service counter is 8 bits wide and never wraps (saturates at SERVE_MAX).

## Timing
- Reset values:
  - pending=0, gnt_valid=0, gnt_id=0, busy=0, timeout=0, overflow=0.
  - FSM in IDLE; round-robin pointer last=15.
- rst mid-transaction aborts immediately. Pending requests are discarded and no timeout pulse is issued.
- Request to grant latency:
  - req[i] in cycle t → pending[i]=1 in t+1.
  - If the FSM is in IDLE, gnt_valid=1 with gnt_id=i in cycle t+2.
- Acceptance: gnt_valid&gnt_ready in cycle a → gnt_valid=0, busy=1 and pending[i]=0 in a+1 (unless re-requested).
- Back-to-back: done in cycle d → IDLE in d+1 → next gnt_valid in d+2 at the earliest.
- gnt_id and gnt_valid are registered outputs with no combinational path from inputs.

## Configuration
- REQ_ARB16_RR_EN defined: round-robin selection.
  - Eligible vector is pending masked to indices > last; if that is empty, all of pending.
  - last updates to gnt_id on acceptance.
  - Every client with a persistent request is granted within 16 transactions.
- Undefined: fixed priority. Lowest set index of pending always wins; last is unused and may be optimized away.

## Test plan
- Reset then req=16'h0001 in one cycle → pending=0x0001 next cycle; gnt_valid=1, gnt_id=0 two cycles after req. gnt_ready=1 → busy=1, pending=0. done → IDLE, busy=0.
- req=16'h8101, gnt_ready tied 1, done one cycle after busy:
  - with REQ_ARB16_RR_EN: grant order 0, 8, 15.
  - without: order 0, 8, 15 as well; then re-assert bit 0 between grants and check that 0 preempts 15 without RR, but not with RR.
- req[3] pulsed twice while pending[3]=1 → overflow=1 and stays set. ovf_clr=1 → overflow=0. ovf_clr and a new overflow in the same cycle → overflow=1.
- SERVE_MAX=4, no done after acceptance → exactly one timeout pulse 4 cycles into SERVE, then IDLE. Repeat with done on the 4th cycle → no timeout.
- gnt_ready held low for 10 cycles while req on other bits toggles → gnt_id stable, gnt_valid stays 1, new bits accumulate in pending.
- rst asserted in SERVE with pending=0x00F0 → next cycle all outputs at reset values; no timeout pulse.
